// File: rtl/dmem_arbiter.sv
// Shares the single-port DataMemo between the MEM stage (default owner) and an
// external loader/debug port. Define DMEM_ARB_STARVE_EN to bound ext starvation.
module dmem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_CPU      = 2'd0,
    S_EXT_ACC  = 2'd1,
    S_EXT_DONE = 2'd2
  } state_t;

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be at least 1");
  end

  state_t state;
  logic   cpu_req;
  logic   ext_sel;
  logic   grant;
  logic   starve_hit;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign ext_sel   = (state == S_EXT_ACC);
  assign grant     = (state == S_CPU) & ext_req & (~cpu_req | starve_hit);
  assign dbg_state = state;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  // Counts CPU-state cycles in which a pending ext request lost to the CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!ext_req || grant) begin
      starve_cnt <= '0;
    end else if ((state == S_CPU) && cpu_req && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
`else
  assign starve_hit = 1'b0;
`endif

  // Ext handshake: ext_req is held with stable ext_we/addr/wdata until ext_ack,
  // a one-cycle registered pulse in EXT_DONE; ext_req is ignored during EXT_DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_CPU;
      ext_ack   <= 1'b0;
      ext_rdata <= '0;
    end else begin
      ext_ack <= 1'b0;
      case (state)
        S_CPU: begin
          if (grant) state <= S_EXT_ACC;
        end
        S_EXT_ACC: begin
          state   <= S_EXT_DONE;
          ext_ack <= 1'b1;
          if (!ext_we) ext_rdata <= mem_rdata;
        end
        S_EXT_DONE: begin
          state <= S_CPU;
        end
        default: begin
          state <= S_CPU;
        end
      endcase
    end
  end

  // Reset gating makes an aborted ext write drop immediately, not at the next edge.
  always_comb begin
    mem_addr  = ext_sel ? ext_addr  : cpu_addr;
    mem_wdata = ext_sel ? ext_wdata : cpu_wdata;
    mem_wr    = reset & (ext_sel ? ext_we  : cpu_wr);
    mem_rd    = reset & (ext_sel ? ~ext_we : (cpu_rd & ~cpu_wr));
    cpu_stall = reset & ext_sel & cpu_req;
    cpu_rdata = ext_sel ? '0 : mem_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word DataMemo model.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [5:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [5:0]  ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        mem_rd, mem_wr;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [64];

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        cpu_rd, cpu_wr;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        ext_req, ext_we;
    logic [5:0]  ext_addr;
    logic [31:0] ext_wdata;
    logic [1:0]  e_state;
    logic        e_mem_rd, e_mem_wr;
    logic [5:0]  e_mem_addr;
    logic        e_stall, e_ack;
    logic [31:0] e_cpu_rdata, e_ext_rdata;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(
    logic crd, logic cwr, logic [5:0] ca, logic [31:0] cwd,
    logic er, logic ew, logic [5:0] ea, logic [31:0] ewd,
    logic [1:0] st, logic mrd, logic mwr, logic [5:0] ma,
    logic stall, logic ack, logic [31:0] crdata, logic [31:0] erdata);
    vec_t v;
    v.cpu_rd = crd;  v.cpu_wr = cwr;  v.cpu_addr = ca;  v.cpu_wdata = cwd;
    v.ext_req = er;  v.ext_we = ew;   v.ext_addr = ea;  v.ext_wdata = ewd;
    v.e_state = st;  v.e_mem_rd = mrd; v.e_mem_wr = mwr; v.e_mem_addr = ma;
    v.e_stall = stall; v.e_ack = ack; v.e_cpu_rdata = crdata; v.e_ext_rdata = erdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic crd, input logic cwr, input logic [5:0] ca,
                       input logic [31:0] cwd, input logic er, input logic ew,
                       input logic [5:0] ea, input logic [31:0] ewd);
    cpu_rd = crd; cpu_wr = cwr; cpu_addr = ca; cpu_wdata = cwd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ewd;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    @(negedge clk);
    drive(v.cpu_rd, v.cpu_wr, v.cpu_addr, v.cpu_wdata,
          v.ext_req, v.ext_we, v.ext_addr, v.ext_wdata);
    #2;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".state"},     32'(dbg_state), 32'(v.e_state));
    chk({tag, ".mem_rd"},    32'(mem_rd),    32'(v.e_mem_rd));
    chk({tag, ".mem_wr"},    32'(mem_wr),    32'(v.e_mem_wr));
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'(v.e_mem_addr));
    chk({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(v.e_stall));
    chk({tag, ".ext_ack"},   32'(ext_ack),   32'(v.e_ack));
    chk({tag, ".cpu_rdata"}, cpu_rdata,      v.e_cpu_rdata);
    chk({tag, ".ext_rdata"}, ext_rdata,      v.e_ext_rdata);
  endtask

  initial begin
    int ack_at, stall_at;

    //              crd cwr ca  cwd           er ew ea  ewd          st rd wr ma stl ack crdata        erdata
    vecs[0]  = mk(0, 0,  0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 0,  0, 0, 0, 32'h0,        32'h0);
    vecs[1]  = mk(0, 1, 10, 32'hAAAA5555, 0, 0,  0, 32'h0,        0, 0, 1, 10, 0, 0, 32'h0,        32'h0);
    vecs[2]  = mk(1, 0, 10, 32'h0,        0, 0,  0, 32'h0,        0, 1, 0, 10, 0, 0, 32'hAAAA5555, 32'h0);
    vecs[3]  = mk(0, 0,  0, 32'hDEAD0000, 1, 1, 20, 32'h12345678, 0, 0, 0,  0, 0, 0, 32'h0,        32'h0);
    vecs[4]  = mk(0, 0,  0, 32'hDEAD0000, 1, 1, 20, 32'h12345678, 1, 0, 1, 20, 0, 0, 32'h0,        32'h0);
    vecs[5]  = mk(0, 0,  0, 32'h0,        1, 1, 20, 32'h12345678, 2, 0, 0,  0, 0, 1, 32'h0,        32'h0);
    vecs[6]  = mk(0, 0,  0, 32'h0,        1, 1, 20, 32'h12345678, 0, 0, 0,  0, 0, 0, 32'h0,        32'h0);
    vecs[7]  = mk(0, 0,  0, 32'h0,        1, 1, 20, 32'h12345678, 1, 0, 1, 20, 0, 0, 32'h0,        32'h0);
    vecs[8]  = mk(1, 0, 20, 32'h0,        0, 0,  0, 32'h0,        2, 1, 0, 20, 0, 1, 32'h12345678, 32'h0);
    vecs[9]  = mk(0, 0,  0, 32'h0,        1, 0, 10, 32'h0,        0, 0, 0,  0, 0, 0, 32'h0,        32'h0);
    vecs[10] = mk(1, 0, 20, 32'h0,        1, 0, 10, 32'h0,        1, 1, 0, 10, 1, 0, 32'h0,        32'h0);
    vecs[11] = mk(1, 0, 20, 32'h0,        0, 0,  0, 32'h0,        2, 1, 0, 20, 0, 1, 32'h12345678, 32'hAAAA5555);
    vecs[12] = mk(0, 0,  0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 0,  0, 0, 0, 32'h0,        32'hAAAA5555);
    vecs[13] = mk(1, 1, 30, 32'h0000BEEF, 0, 0,  0, 32'h0,        0, 0, 1, 30, 0, 0, 32'h0,        32'hAAAA5555);
    vecs[14] = mk(1, 0, 30, 32'h0,        0, 0,  0, 32'h0,        0, 1, 0, 30, 0, 0, 32'h0000BEEF, 32'hAAAA5555);
    vecs[15] = mk(1, 0, 30, 32'h0,        1, 0, 10, 32'h0,        0, 1, 0, 30, 0, 0, 32'h0000BEEF, 32'hAAAA5555);
    vecs[16] = mk(0, 0,  0, 32'h0,        0, 0, 10, 32'h0,        0, 0, 0,  0, 0, 0, 32'h0,        32'hAAAA5555);

    // reset block: illegal CPU request while reset is low must not reach memory
    reset = 1'b0;
    drive(1, 1, 6'd5, 32'h1, 1, 1, 6'd7, 32'h2);
    #2;
    chk("rst.mem_wr",    32'(mem_wr),    32'h0);
    chk("rst.mem_rd",    32'(mem_rd),    32'h0);
    chk("rst.cpu_stall", 32'(cpu_stall), 32'h0);
    chk("rst.ext_ack",   32'(ext_ack),   32'h0);
    chk("rst.ext_rdata", ext_rdata,      32'h0);
    chk("rst.state",     32'(dbg_state), 32'h0);
    chk("rst.mem_addr",  32'(mem_addr),  32'd5);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // starvation: continuous CPU loads with a pending ext read of addr 10
    ack_at = -1;
    stall_at = -1;
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      drive(1, 0, 6'd0, 32'h0, 1, 0, 6'd10, 32'h0);
      #2;
      if (cpu_stall && stall_at < 0) stall_at = i;
      if (ext_ack) begin
        ack_at = i;
        break;
      end
    end
`ifdef DMEM_ARB_STARVE_EN
    chk("starve.ack_cycle",   32'(ack_at),   32'd6);
    chk("starve.stall_cycle", 32'(stall_at), 32'd5);
    chk("starve.ext_rdata",   ext_rdata,     32'hAAAA5555);
`else
    chk("starve.no_ack",   32'(ack_at),   32'hFFFFFFFF);
    chk("starve.no_stall", 32'(stall_at), 32'hFFFFFFFF);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("idle.state", 32'(dbg_state), 32'h0);

    // reset during EXT_ACC of an ext write of FFFFFFFF to addr 10
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 6'd10, 32'hFFFFFFFF);
    @(negedge clk);
    #2;
    chk("abort.pre_mem_wr", 32'(mem_wr),    32'h1);
    chk("abort.pre_state",  32'(dbg_state), 32'h1);
    reset = 1'b0;
    #1;
    chk("abort.mem_wr",  32'(mem_wr),    32'h0);
    chk("abort.state",   32'(dbg_state), 32'h0);
    chk("abort.ext_ack", 32'(ext_ack),   32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("abort.post_ack", 32'(ext_ack), 32'h0);
    @(negedge clk);
    drive(1, 0, 6'd10, 32'h0, 0, 0, 0, 0);
    #2;
    chk("abort.ack_later",  32'(ext_ack), 32'h0);
    chk("abort.addr10",     cpu_rdata,    32'hAAAA5555);
    chk("abort.ext_rdata",  ext_rdata,    32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port data memory (DataMemo) between the pipeline MEM stage and an external loader/debug port. The CPU port passes through to memory combinationally and has default priority. External accesses run as a registered req/ack transaction. The arbiter raises a stall toward the hazard/PC logic whenever the CPU must wait for the memory.

## Interface
- ADDR_W, 6, word-address width (64-word DataMemo)
- DATA_W, 32, data width
- STARVE_MAX, 4, maximum consecutive denied cycles for ext before a forced grant (used only with DMEM_ARB_STARVE_EN); must be ≥1
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_rd  in  1  MEM-stage load request
- cpu_wr  in  1  MEM-stage store request
- cpu_addr  in  ADDR_W  MEM-stage address
- cpu_wdata  in  DATA_W  MEM-stage store data
- cpu_rdata  out  DATA_W  load data to MEM stage (mem_rdata when CPU owns memory, else 0)
- cpu_stall  out  1  CPU access not serviced this cycle; feeds disable_PC/disable_IR
- ext_req  in  1  external transaction request, held high until ext_ack
- ext_we  in  1  1 = write, 0 = read; stable while ext_req high
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_ack  out  1  one-cycle completion pulse (registered)
- ext_rdata  out  DATA_W  registered read data, valid with ext_ack, held until next ext read
- mem_rd  out  1  to DataMemo MemRd
- mem_wr  out  1  to DataMemo MemWr_final
- mem_addr  out  ADDR_W  to DataMemo Address
- mem_wdata  out  DATA_W  to DataMemo Data_in
- mem_rdata  in  DATA_W  from DataMemo Data_out (combinational read)

## Operation
- States: CPU (default), EXT_ACC, EXT_DONE; 2-bit state register.
- CPU: memory muxed to CPU port; mem_rd = cpu_rd & ~cpu_wr, mem_wr = cpu_wr. cpu_stall = 0.
- CPU → EXT_ACC when ext_req & (~(cpu_rd|cpu_wr) | starve_hit); else stay.
- EXT_ACC (exactly one cycle): memory muxed to ext port; mem_wr = ext_we, mem_rd = ~ext_we. cpu_stall = cpu_rd|cpu_wr; cpu_rdata = 0. On the exiting edge, ext_rdata ← mem_rdata if read (unchanged on write). → EXT_DONE unconditionally.
- EXT_DONE: memory back to CPU (same as CPU state); ext_ack = 1; ext_req ignored (no back-to-back grant). → CPU.
- ext_req dropped while in CPU state: nothing happens. Once EXT_ACC is entered, the transaction completes regardless of ext_req.
- cpu_rd and cpu_wr both high is illegal; write wins, mem_rd = 0.
- While reset is low: mem_rd = mem_wr = 0, cpu_stall = 0, ext_ack = 0.

## Timing
- Reset values: state CPU, ext_ack 0, ext_rdata 0, starve counter 0. All combinational outputs follow the CPU state, with mem_rd/mem_wr forced to 0.
- CPU access: zero-latency, same cycle. Store commits on the rising edge of the request cycle.
- Ext transaction: grant decision in cycle N (CPU state), access in N+1, ext_ack in N+2. Minimum ext_req-to-ack is 2 cycles; the next grant is at N+3 at the earliest.
- CPU penalty: at most 1 stall cycle per ext transaction (the EXT_ACC cycle).
- Reset asserted during EXT_ACC: the access is aborted (mem_wr drops asynchronously), no ack is issued, and the requester must re-request.

## Configuration
- DMEM_ARB_STARVE_EN defined:
  - A saturating counter of width $clog2(STARVE_MAX+1) increments each CPU-state cycle with ext_req & (cpu_rd|cpu_wr).
  - It clears when ext_req is low or on entry to EXT_ACC.
  - starve_hit = (count == STARVE_MAX); it forces the grant even with an active CPU request, which is then stalled in EXT_ACC.
- Not defined: no counter, starve_hit = 0. CPU has strict priority, and ext may starve indefinitely under continuous CPU traffic.

## Test plan
- CPU store addr 10 = AAAA5555, next cycle CPU load addr 10 -> cpu_rdata AAAA5555, cpu_stall 0 throughout, ext_ack never pulses.
- CPU idle, ext write addr 20 = 12345678 -> mem_wr high exactly one cycle (N+1), ext_ack at N+2. A following CPU load of addr 20 returns 12345678.
- Ext read addr 10 while CPU issues a load in the EXT_ACC cycle -> cpu_stall 1 for that one cycle, ext_rdata AAAA5555 with ext_ack, CPU load serviced in EXT_DONE.
- Continuous CPU traffic plus ext_req, with STARVE_EN and STARVE_MAX=4 -> grant after 4 denied cycles, ext_ack at denied-start+6. Without the macro, no ext_ack within 50 cycles.
- Reset driven low during EXT_ACC of an ext write of FFFFFFFF to addr 10 -> no ack, mem_wr 0 immediately, addr 10 still AAAA5555 after reset release.
- ext_req held high through ack -> no second EXT_ACC in the EXT_DONE cycle. A new grant occurs one cycle after ext_ack at the earliest.
